// File: rtl/patch_dump_master.sv
// rtl/patch_dump_master.sv - parameter-bank SysEx dump initiator
//
// Walks each bank selected in dump_mask, reads registers 0..ADR_LAST over the
// shared adr/read/synth_data_out bus and streams one SysEx message per bank:
//   F0, MFR_ID, bank index, {hi nibble, lo nibble} per register, checksum, F7
//
// Ports
//   data_clk               clock, all state on its rising edge
//   reset_data             asynchronous active-high reset
//   dump_req / dump_mask   start pulse and bank mask, sampled only in IDLE
//   busy / dump_done       dump in progress / one-cycle completion pulse
//   sel / adr / read       one-hot bank select, register address, read strobe
//   sysex_data_patch_send  enables responder drivers on the shared bus
//   synth_data_out         shared readback bus
//   tx_data / tx_valid / tx_ready  outgoing byte stream, transfer on valid&&ready

module patch_dump_master #(
  parameter int         N_SEL    = 4,
  parameter int         ADR_LAST = 127,
  parameter logic [7:0] MFR_ID   = 8'h7D
) (
  input  logic             data_clk,
  input  logic             reset_data,
  input  logic             dump_req,
  input  logic [N_SEL-1:0] dump_mask,
  output logic             busy,
  output logic             dump_done,
  output logic [N_SEL-1:0] sel,
  output logic [6:0]       adr,
  output logic             read,
  output logic             sysex_data_patch_send,
  input  logic [7:0]       synth_data_out,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int         BW         = (N_SEL > 1) ? $clog2(N_SEL) : 1;
  localparam logic [6:0] ADR_LAST_L = 7'(ADR_LAST);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_RD_ADR,
    S_RD_WAIT,
    S_TX_HI,
    S_TX_LO,
    S_CSUM,
    S_EOX,
    S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [N_SEL-1:0] mask_q, mask_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [6:0]       adr_q, adr_d;
  logic [6:0]       sum_q, sum_d;
  logic [7:0]       rdata_q, rdata_d;

  logic [N_SEL-1:0] bank_onehot;
  logic [N_SEL-1:0] mask_left;
  logic [6:0]       bank_idx7;
  logic             xfer;

  // Index of the lowest set bit; banks are always dumped in ascending order.
  function automatic logic [BW-1:0] lowest_bank(input logic [N_SEL-1:0] m);
    lowest_bank = '0;
    for (int i = N_SEL - 1; i >= 0; i--) begin
      if (m[i]) lowest_bank = BW'(i);
    end
  endfunction

  assign bank_onehot = N_SEL'(1) << bank_q;
  // Banks still pending once the current one is finished.
  assign mask_left   = mask_q & ~bank_onehot;
  assign bank_idx7   = 7'(bank_q);
  assign xfer        = tx_valid && tx_ready;
  assign adr         = adr_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge data_clk or posedge reset_data) begin
    if (reset_data) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      bank_q  <= '0;
      adr_q   <= '0;
      sum_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      adr_q   <= adr_d;
      sum_q   <= sum_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    adr_d   = adr_q;
    sum_d   = sum_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        // A request with an empty mask is dropped without ever raising busy.
        if (dump_req && (|dump_mask)) begin
          state_d = S_HDR0;
          mask_d  = dump_mask;
          bank_d  = lowest_bank(dump_mask);
          adr_d   = '0;
          sum_d   = '0;
        end
      end

      S_HDR0: if (xfer) state_d = S_HDR1;
      S_HDR1: if (xfer) state_d = S_HDR2;
      S_HDR2: if (xfer) state_d = S_RD_ADR;

      S_RD_ADR: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        // Responder registered the data at the end of RD_ADR, so the bus is
        // valid throughout this cycle.
        rdata_d = synth_data_out;
        state_d = S_TX_HI;
      end

      S_TX_HI: begin
        if (xfer) begin
          sum_d   = sum_q + {3'b000, rdata_q[7:4]};
          state_d = S_TX_LO;
        end
      end

      S_TX_LO: begin
        if (xfer) begin
          sum_d = sum_q + {3'b000, rdata_q[3:0]};
          if (adr_q != ADR_LAST_L) begin
            adr_d   = adr_q + 7'd1;
            state_d = S_RD_ADR;
          end else begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: if (xfer) state_d = S_EOX;
      S_EOX:  if (xfer) state_d = S_NEXT;

      S_NEXT: begin
        mask_d = mask_left;
        adr_d  = '0;
        sum_d  = '0;
        if (|mask_left) begin
          bank_d  = lowest_bank(mask_left);
          state_d = S_HDR0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only so that tx_data/tx_valid hold
  // steady under backpressure and everything drops to 0 the moment reset hits.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy                  = (state_q != S_IDLE);
    dump_done             = 1'b0;
    sel                   = '0;
    read                  = 1'b0;
    sysex_data_patch_send = 1'b0;
    tx_valid              = 1'b0;
    tx_data               = 8'h00;

    case (state_q)
      S_HDR0: begin
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
      end
      S_HDR1: begin
        tx_valid = 1'b1;
        tx_data  = MFR_ID;
      end
      S_HDR2: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, bank_idx7};
      end
      S_RD_ADR: begin
        sel                   = bank_onehot;
        read                  = 1'b1;
        sysex_data_patch_send = 1'b1;
      end
      S_RD_WAIT: begin
        sel                   = bank_onehot;
        sysex_data_patch_send = 1'b1;
      end
      S_TX_HI: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, rdata_q[7:4]};
      end
      S_TX_LO: begin
        tx_valid = 1'b1;
        tx_data  = {4'h0, rdata_q[3:0]};
      end
      S_CSUM: begin
        // Two's complement of the running 7-bit sum: nibbles + checksum == 0 mod 128.
        tx_valid = 1'b1;
        tx_data  = {1'b0, 7'h00 - sum_q};
      end
      S_EOX: begin
        tx_valid = 1'b1;
        tx_data  = 8'hF7;
      end
      S_NEXT: begin
        dump_done = ~(|mask_left);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_patch_dump_master.sv
// tb/tb_patch_dump_master.sv - scoreboard bench for patch_dump_master

module tb_patch_dump_master;

  logic       data_clk = 1'b0;
  logic       reset_data = 1'b1;
  logic       dump_req = 1'b0;
  logic [3:0] dump_mask = 4'h0;
  logic       busy, dump_done;
  logic [3:0] sel;
  logic [6:0] adr;
  logic       read, send;
  logic [7:0] synth_data_out;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  patch_dump_master #(.N_SEL(4), .ADR_LAST(127), .MFR_ID(8'h7D)) dut (
    .data_clk              (data_clk),
    .reset_data            (reset_data),
    .dump_req              (dump_req),
    .dump_mask             (dump_mask),
    .busy                  (busy),
    .dump_done             (dump_done),
    .sel                   (sel),
    .adr                   (adr),
    .read                  (read),
    .sysex_data_patch_send (send),
    .synth_data_out        (synth_data_out),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready)
  );

  always #5 data_clk = ~data_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder model: registers the addressed register at the end of the read cycle.
  logic [7:0] mem [4][128];
  logic [7:0] resp_q;
  always @(posedge data_clk) begin
    if (read) begin
      for (int b = 0; b < 4; b++) if (sel[b]) resp_q <= mem[b][adr];
    end
  end
  assign synth_data_out = send ? resp_q : 8'h00;

  // tx_ready driver: 0 = low, 1 = high, 2 = random ~30% duty
  int ready_mode = 1;
  always @(posedge data_clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = ($urandom_range(0, 9) < 3);
    endcase
  end

  // Scoreboards
  logic [7:0]  exp_q [$];
  logic [10:0] rd_q [$];
  logic [7:0]  got [$];
  int busy_cycles = 0, done_cnt = 0, rd_cnt = 0, sel1_cnt = 0, sel3_cnt = 0;

  task automatic push_dump(input logic [3:0] m);
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        int s;
        logic [7:0] d;
        s = 0;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h7D);
        exp_q.push_back(8'(b));
        for (int a = 0; a < 128; a++) begin
          d = mem[b][a];
          exp_q.push_back({4'h0, d[7:4]});
          exp_q.push_back({4'h0, d[3:0]});
          s = s + int'(d[7:4]) + int'(d[3:0]);
          rd_q.push_back({4'(1 << b), 7'(a)});
        end
        exp_q.push_back(8'((128 - (s % 128)) % 128));
        exp_q.push_back(8'hF7);
      end
    end
  endtask

  // Monitor, sampled on the falling edge
  logic       prev_stall = 1'b0, prev_read = 1'b0;
  logic [7:0] prev_data;
  logic [6:0] prev_adr;
  logic [3:0] prev_sel;
  always @(negedge data_clk) begin
    if (reset_data) begin
      exp_q.delete();
      rd_q.delete();
      prev_stall = 1'b0;
      prev_read  = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (dump_done) done_cnt++;
      if (sel[1]) sel1_cnt++;
      if (sel[3]) sel3_cnt++;
      if (prev_stall) begin
        check_eq("hold_valid", tx_valid, 1);
        check_eq("hold_data", tx_data, prev_data);
      end
      if (prev_read) begin
        check_eq("rd_pulse", read, 0);
        check_eq("rd_hold_adr", adr, prev_adr);
        check_eq("rd_hold_sel", sel, prev_sel);
        check_eq("rd_hold_send", send, 1);
      end
      if (read) begin
        rd_cnt++;
        if (rd_q.size() == 0) check_eq("rd_unexpected", rd_q.size(), 1);
        else begin
          logic [10:0] e;
          e = rd_q.pop_front();
          check_eq("rd_sel_adr", {sel, adr}, e);
          check_eq("rd_send", send, 1);
        end
      end
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (exp_q.size() == 0) check_eq("byte_unexpected", exp_q.size(), 1);
        else check_eq("byte", tx_data, exp_q.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_read  = read;
      prev_adr   = adr;
      prev_sel   = sel;
    end
  end

  task automatic start_dump(input logic [3:0] m);
    @(posedge data_clk);
    #1;
    dump_mask = m;
    dump_req  = 1'b1;
    @(posedge data_clk);
    #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    @(posedge data_clk);
    while (busy && n < bound) begin
      @(posedge data_clk);
      n++;
    end
    #1;
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
    check_eq({tag, "_rd_empty"}, rd_q.size(), 0);
  endtask

  int gb, db, bb, rb, s1b, s3b, n;

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 128; a++) mem[b][a] = 8'h00;
    mem[0][6] = 8'hA5;

    repeat (3) @(posedge data_clk);
    #1 reset_data = 1'b0;
    @(negedge data_clk);
    check_eq("rst_outputs", {busy, dump_done, sel, adr, read, send, tx_data, tx_valid}, 0);

    // Single bank, ready high
    ready_mode = 1;
    gb = got.size(); db = done_cnt; bb = busy_cycles; rb = rd_cnt;
    push_dump(4'b0001);
    start_dump(4'b0001);
    check_eq("accept", {busy, tx_valid, tx_data}, {1'b1, 1'b1, 8'hF0});
    wait_idle("single", 2000);
    check_eq("single_len", got.size() - gb, 261);
    check_eq("single_hdr", {got[gb], got[gb+1], got[gb+2]}, 24'hF07D00);
    check_eq("single_a6", {got[gb+15], got[gb+16]}, 16'h0A05);
    check_eq("single_csum", got[gb+259], 8'h71);
    check_eq("single_eox", got[gb+260], 8'hF7);
    check_eq("single_done", done_cnt - db, 1);
    check_eq("single_busy_cyc", busy_cycles - bb, 518);
    check_eq("single_reads", rd_cnt - rb, 128);

    // Same dump under random backpressure
    ready_mode = 2;
    gb = got.size(); db = done_cnt;
    push_dump(4'b0001);
    start_dump(4'b0001);
    wait_idle("bp", 8000);
    check_eq("bp_len", got.size() - gb, 261);
    check_eq("bp_csum", got[gb+259], 8'h71);
    check_eq("bp_done", done_cnt - db, 1);

    // Two banks, all registers FF
    ready_mode = 1;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 128; a++) mem[b][a] = 8'hFF;
    gb = got.size(); db = done_cnt; rb = rd_cnt; s1b = sel1_cnt; s3b = sel3_cnt;
    push_dump(4'b0101);
    start_dump(4'b0101);
    wait_idle("two", 4000);
    check_eq("two_len", got.size() - gb, 522);
    check_eq("two_bank0", got[gb+2], 8'h00);
    check_eq("two_bank2", got[gb+263], 8'h02);
    check_eq("two_data", got[gb+3], 8'h0F);
    check_eq("two_csum", {got[gb+259], got[gb+520]}, 16'h0000);
    check_eq("two_done", done_cnt - db, 1);
    check_eq("two_reads", rd_cnt - rb, 256);
    check_eq("two_no_sel1", sel1_cnt - s1b, 0);
    check_eq("two_no_sel3", sel3_cnt - s3b, 0);

    // Mask 0 request while idle is ignored
    start_dump(4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge data_clk);
      check_eq("mask0_idle", {busy, tx_valid}, 0);
    end

    // Re-pulse mid-dump is ignored
    for (int a = 0; a < 128; a++) mem[0][a] = 8'(a * 3 + 1);
    gb = got.size(); db = done_cnt;
    push_dump(4'b0001);
    start_dump(4'b0001);
    repeat (100) @(posedge data_clk);
    start_dump(4'b1111);
    wait_idle("repulse", 2000);
    check_eq("repulse_len", got.size() - gb, 261);
    check_eq("repulse_done", done_cnt - db, 1);

    // Reset while TX_LO of bank 0 is stalled
    gb = got.size();
    push_dump(4'b0001);
    start_dump(4'b0001);
    n = 0;
    while (got.size() < gb + 4 && n < 200) begin
      @(posedge data_clk);
      n++;
    end
    ready_mode = 0;
    @(negedge data_clk);
    check_eq("pre_rst_lo", {tx_valid, tx_data}, {1'b1, 8'h01});
    #1 reset_data = 1'b1;
    #1;
    check_eq("mid_rst_outputs", {busy, dump_done, sel, adr, read, send, tx_data, tx_valid}, 0);
    @(posedge data_clk);
    @(negedge data_clk);
    #1 reset_data = 1'b0;
    ready_mode = 1;
    gb = got.size(); db = done_cnt;
    push_dump(4'b0001);
    start_dump(4'b0001);
    wait_idle("post_rst", 2000);
    check_eq("post_rst_len", got.size() - gb, 261);
    check_eq("post_rst_f0", got[gb], 8'hF0);
    check_eq("post_rst_done", done_cnt - db, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
